mux2_arb: RTL
=============

MUX2_ARB -- requirements
Module: mux2_arb

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8: maximum grant length in cycles; legal range 2..255.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port req, input, 2: req[i] = requester i wants the shared mux2 output.
REQ-005 SHALL have port last, input, 2: last[i] = final cycle of requester i's transfer; ignored unless grant[i]=1.
REQ-006 SHALL have port grant, output, 2: one-hot or zero; grant[i] = requester i owns the mux.
REQ-007 SHALL have port sel, output, 1: drives mux2 sel; 0 = d0 (requester 0), 1 = d1 (requester 1).
REQ-008 SHALL have port busy, output, 1: high while either grant bit is high.

Function
REQ-009 SHALL implement FSM states IDLE, GNT0, GNT1; grant = 2'b01 in GNT0, 2'b10 in GNT1, 2'b00 in IDLE.
REQ-010 SHALL register all outputs; grant appears the cycle after req is sampled (1-cycle latency).
REQ-011 IDLE: req=01 -> GNT0; req=10 -> GNT1; req=11 -> state of the requester not served last (round-robin); req=00 -> stay IDLE.
REQ-012 GNTi SHALL hold while req[i]=1 and last[i]=0.
REQ-013 GNTi SHALL release when last[i]=1 or req[i]=0; the next state is decided in the same cycle as the release.
REQ-014 On release, if req of the other requester is 1, next state SHALL be GNTother (no idle bubble); otherwise IDLE.
REQ-015 A requester SHALL NOT be re-granted on the cycle after its own release while the other requests.
REQ-016 Round-robin pointer SHALL update to i on every entry into GNTi.
REQ-017 sel SHALL be 1 in GNT1 and 0 in GNT0, and SHALL hold its last value in IDLE (no glitch on the mux).
REQ-018 grant SHALL never be 2'b11 under any input sequence, including X-free random stimulus.
REQ-019 last[i] with grant[i]=0 SHALL have no effect.

Reset
REQ-020 On rst=1 at a clock edge: state IDLE, grant=00, sel=0, busy=0, round-robin pointer=1 (requester 0 wins the first tie), hold counter=0.
REQ-021 Reset mid-grant SHALL drop grant the next cycle regardless of req/last; rst dominates all other inputs.

Configuration
REQ-022 Macro MUX2_ARB_TIMEOUT_EN defined: a hold counter counts cycles in GNTi from 0; when it reaches MAX_HOLD-1 and the other requester has req=1, a forced release SHALL occur as in REQ-014; the counter SHALL clear on every state change.
REQ-023 Macro MUX2_ARB_TIMEOUT_EN undefined: no counter is instantiated and grant length is unbounded; MAX_HOLD is unused.
REQ-024 The timeout SHALL NOT force a release when the other requester has req=0; the counter SHALL saturate at MAX_HOLD-1.

Structure
REQ-025 Package mux2_arb_pkg SHALL hold the state enum (IDLE, GNT0, GNT1) and the localparam for requester count (2).
REQ-026 Sub-module mux2_arb_cnt (saturating hold counter, width $clog2(MAX_HOLD)) SHALL be instantiated only under MUX2_ARB_TIMEOUT_EN.
REQ-027 The block SHALL instantiate no mux; sel connects externally to mux2.sel.

Verification
REQ-028 Single requester: rst, then req=01 at cycle 2 and last[0]=1 at cycle 5 -> grant=01 cycles 3..5, 00 at cycle 6, sel=0 throughout.
REQ-029 Tie after reset: req=11 from cycle 2 -> grant=01 at cycle 3; last[0] at cycle 4 -> grant=10 at cycle 5, sel=1, no IDLE cycle.
REQ-030 Fairness: req=11 held, last pulsed every 3rd granted cycle for 12 cycles -> grants alternate 01,10,01,10; no requester is granted twice in a row.
REQ-031 Withdraw: grant=10, req[1] drops to 0 with req[0]=0 -> grant=00 next cycle, sel stays 1.
REQ-032 Timeout (MUX2_ARB_TIMEOUT_EN, MAX_HOLD=4): req=11, last=00 -> grant=01 for exactly 4 cycles, then 10 for 4, repeating; with the macro undefined -> grant=01 indefinitely.
REQ-033 Reset mid-grant: rst=1 during GNT1 -> next cycle grant=00, sel=0, busy=0; after rst release, req=11 -> grant=01.

Source files
------------

// File: rtl/mux2_arb_pkg.sv
// Shared types for the two-requester mux arbiter.
package mux2_arb_pkg;
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;
endpackage

// File: rtl/mux2_arb_cnt.sv
// Saturating hold counter: counts granted cycles, clears on any arbiter
// state change, sticks at MAX_HOLD-1 and flags it.
module mux2_arb_cnt #(
  parameter int MAX_HOLD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic at_max
);
  localparam int W = $clog2(MAX_HOLD);
  localparam logic [W-1:0] TOP = W'(MAX_HOLD - 1);

  logic [W-1:0] cnt;

  // count while a grant is held, restart from zero on every state change
  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en && cnt != TOP)
      cnt <= cnt + 1'b1;
  end

  assign at_max = (cnt == TOP);
endmodule

// File: rtl/mux2_arb.sv
// Two-requester round-robin arbiter driving an external mux2 select.
// Optional grant timeout enabled with macro MUX2_ARB_TIMEOUT_EN.
module mux2_arb
  import mux2_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   last,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 sel,
  output logic                 busy
);
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
    $error("mux2_arb: MAX_HOLD must be in 2..255");
  end

  state_t state;
  logic   rr;     // requester served most recently
  logic   cur;    // index of the current owner (valid in GNT0/GNT1)
  logic   held;   // in a grant state
  logic   tmo;    // forced release due to hold limit
  logic   rel;    // current owner gives up the mux this cycle
  logic   start;  // leaving IDLE this cycle
  logic   go;     // entering a grant state this cycle
  logic   tgt;    // requester that receives the next grant

  assign held  = (state == GNT0) || (state == GNT1);
  assign cur   = (state == GNT1);

`ifdef MUX2_ARB_TIMEOUT_EN
  logic at_max;

  mux2_arb_cnt #(.MAX_HOLD(MAX_HOLD)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (start || rel),
    .en     (held),
    .at_max (at_max)
  );

  // only cut a grant short when somebody is actually waiting
  assign tmo = at_max && req[~cur];
`else
  assign tmo = 1'b0;
`endif

  assign rel   = held && (!req[cur] || last[cur] || tmo);
  assign start = (state == IDLE) && (req != '0);
  assign go    = start || (rel && req[~cur]);
  // on a tie in IDLE the requester not served last wins; on release the
  // other requester is the only candidate, which also stops a re-grant
  assign tgt   = (state == IDLE) ? ((req == 2'b11) ? ~rr : req[1]) : ~cur;

  // arbiter FSM with registered outputs; sel keeps its value in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      sel   <= 1'b0;
      busy  <= 1'b0;
      rr    <= 1'b1;
    end else if (!(state inside {IDLE, GNT0, GNT1})) begin
      state <= IDLE;
      grant <= '0;
      busy  <= 1'b0;
    end else if (go) begin
      state <= tgt ? GNT1 : GNT0;
      grant <= tgt ? 2'b10 : 2'b01;
      sel   <= tgt;
      busy  <= 1'b1;
      rr    <= tgt;
    end else if (rel) begin
      state <= IDLE;
      grant <= '0;
      busy  <= 1'b0;
    end
  end
endmodule
